// File: rtl/vga_timing.sv
// SVGA 800x600@60 raster timing generator: counters, sync pulses, blanking and start-of-frame.
// Optional 16-bit frame counter output when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing #(
   parameter int unsigned H_ACTIVE = 800,
   parameter int unsigned H_FP     = 40,
   parameter int unsigned H_SYNC   = 128,
   parameter int unsigned H_BP     = 88,
   parameter int unsigned V_ACTIVE = 600,
   parameter int unsigned V_FP     = 1,
   parameter int unsigned V_SYNC   = 4,
   parameter int unsigned V_BP     = 23,
   parameter bit          SYNC_POL = 1'b1
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        en,
   output logic [10:0] hcount_out,
   output logic        hsync_out,
   output logic        hblnk_out,
   output logic [10:0] vcount_out,
   output logic        vsync_out,
   output logic        vblnk_out,
   output logic        sof_out
`ifdef VGA_TIMING_FRAME_CNT_EN
   ,
   output logic [15:0] frame_cnt_out
`endif
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_bad_total
      $error("vga_timing: H_TOTAL/V_TOTAL exceed 11-bit counter range");
   end

   localparam logic [10:0] HLast      = 11'(H_TOTAL - 1);
   localparam logic [10:0] VLast      = 11'(V_TOTAL - 1);
   localparam logic [10:0] HBlnkStart = 11'(H_ACTIVE);
   localparam logic [10:0] HSyncStart = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HSyncEnd   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VBlnkStart = 11'(V_ACTIVE);
   localparam logic [10:0] VSyncStart = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VSyncEnd   = 11'(V_ACTIVE + V_FP + V_SYNC);

   logic [10:0] hcount_q, hcount_d;
   logic [10:0] vcount_q, vcount_d;
   logic        hsync_q, hsync_d;
   logic        hblnk_q, hblnk_d;
   logic        vsync_q, vsync_d;
   logic        vblnk_q, vblnk_d;
   logic        sof_q, sof_d;
   logic        h_wrap, v_wrap;

   // Flags are derived from the next counts so they register in step with the counters.
   always_comb begin
      h_wrap   = (hcount_q == HLast);
      v_wrap   = (vcount_q == VLast);
      hcount_d = hcount_q;
      vcount_d = vcount_q;
      hsync_d  = hsync_q;
      hblnk_d  = hblnk_q;
      vsync_d  = vsync_q;
      vblnk_d  = vblnk_q;
      sof_d    = 1'b0;
      if (en) begin
         hcount_d = h_wrap ? 11'd0 : hcount_q + 11'd1;
         if (h_wrap) begin
            vcount_d = v_wrap ? 11'd0 : vcount_q + 11'd1;
         end
         hblnk_d = (hcount_d >= HBlnkStart);
         hsync_d = (hcount_d >= HSyncStart && hcount_d < HSyncEnd) ? SYNC_POL : ~SYNC_POL;
         vblnk_d = (vcount_d >= VBlnkStart);
         vsync_d = (vcount_d >= VSyncStart && vcount_d < VSyncEnd) ? SYNC_POL : ~SYNC_POL;
         sof_d   = h_wrap && v_wrap;
      end
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         hcount_q <= 11'd0;
         vcount_q <= 11'd0;
         hsync_q  <= ~SYNC_POL;
         hblnk_q  <= 1'b0;
         vsync_q  <= ~SYNC_POL;
         vblnk_q  <= 1'b0;
         sof_q    <= 1'b0;
      end else begin
         hcount_q <= hcount_d;
         vcount_q <= vcount_d;
         hsync_q  <= hsync_d;
         hblnk_q  <= hblnk_d;
         vsync_q  <= vsync_d;
         vblnk_q  <= vblnk_d;
         sof_q    <= sof_d;
      end
   end

   assign hcount_out = hcount_q;
   assign vcount_out = vcount_q;
   assign hsync_out  = hsync_q;
   assign hblnk_out  = hblnk_q;
   assign vsync_out  = vsync_q;
   assign vblnk_out  = vblnk_q;
   assign sof_out    = sof_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] frame_q, frame_d;

   always_comb begin
      frame_d = sof_d ? frame_q + 16'd1 : frame_q;
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         frame_q <= 16'd0;
      end else begin
         frame_q <= frame_d;
      end
   end

   assign frame_cnt_out = frame_q;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: full-size instance for horizontal timing and enable hold, plus a shrunken
// negative-polarity instance for vertical timing, start-of-frame and asynchronous reset.
module tb_vga_timing;

   logic pclk = 1'b0;
   logic rst  = 1'b0;
   logic en_a = 1'b0;
   logic en_b = 1'b0;

   logic [10:0] a_hcount, a_vcount, b_hcount, b_vcount;
   logic        a_hsync, a_hblnk, a_vsync, a_vblnk, a_sof;
   logic        b_hsync, b_hblnk, b_vsync, b_vblnk, b_sof;
`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] a_frame, b_frame;
`endif

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;
   int          bh, bv, sofs;
   logic [15:0] bf;

   vga_timing u_a (
      .pclk       (pclk),
      .rst        (rst),
      .en         (en_a),
      .hcount_out (a_hcount),
      .hsync_out  (a_hsync),
      .hblnk_out  (a_hblnk),
      .vcount_out (a_vcount),
      .vsync_out  (a_vsync),
      .vblnk_out  (a_vblnk),
      .sof_out    (a_sof)
`ifdef VGA_TIMING_FRAME_CNT_EN
      ,
      .frame_cnt_out (a_frame)
`endif
   );

   // Small raster: H 8+2+3+2 = 15, V 6+1+2+3 = 12, active-low syncs.
   vga_timing #(
      .H_ACTIVE (8),
      .H_FP     (2),
      .H_SYNC   (3),
      .H_BP     (2),
      .V_ACTIVE (6),
      .V_FP     (1),
      .V_SYNC   (2),
      .V_BP     (3),
      .SYNC_POL (1'b0)
   ) u_b (
      .pclk       (pclk),
      .rst        (rst),
      .en         (en_b),
      .hcount_out (b_hcount),
      .hsync_out  (b_hsync),
      .hblnk_out  (b_hblnk),
      .vcount_out (b_vcount),
      .vsync_out  (b_vsync),
      .vblnk_out  (b_vblnk),
      .sof_out    (b_sof)
`ifdef VGA_TIMING_FRAME_CNT_EN
      ,
      .frame_cnt_out (b_frame)
`endif
   );

   logic [31:0] obs_a, obs_b;
   assign obs_a = {5'd0, a_hcount, a_vcount, a_hblnk, a_hsync, a_vblnk, a_vsync, a_sof};
   assign obs_b = {5'd0, b_hcount, b_vcount, b_hblnk, b_hsync, b_vblnk, b_vsync, b_sof};

   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] vec(input int h, input int v, input bit sof,
                                       input int ha, input int hfp, input int hs,
                                       input int va, input int vfp, input int vs,
                                       input bit pol);
      logic hb, hsy, vb, vsy;
      hb  = (h >= ha);
      hsy = (h >= ha + hfp && h < ha + hfp + hs) ? pol : ~pol;
      vb  = (v >= va);
      vsy = (v >= va + vfp && v < va + vfp + vs) ? pol : ~pol;
      return {5'd0, 11'(h), 11'(v), hb, hsy, vb, vsy, sof};
   endfunction

   function automatic logic [31:0] vec_a(input int h, input int v);
      return vec(h, v, 1'b0, 800, 40, 128, 600, 1, 4, 1'b1);
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge pclk);
      #1;
   endtask

   // Advance the small-raster model one enabled cycle and compare against u_b.
   task automatic run_b(input int n);
      bit s;
      for (int k = 0; k < n; k++) begin
         step(1);
         bh = (bh == 14) ? 0 : bh + 1;
         if (bh == 0) bv = (bv == 11) ? 0 : bv + 1;
         s = (bh == 0 && bv == 0);
         if (s) begin
            sofs++;
            bf = bf + 16'd1;
         end
         chk("b_run", obs_b, vec(bh, bv, s, 8, 2, 3, 6, 1, 2, 0));
`ifdef VGA_TIMING_FRAME_CNT_EN
         chk("b_frame_cnt", {16'd0, b_frame}, {16'd0, bf});
`endif
      end
   endtask

   initial begin
      #1 rst = 1'b1;
      #1;
      chk("a_reset", obs_a, 32'h0000_0000);
      chk("b_reset", obs_b, 32'h0000_000A);
`ifdef VGA_TIMING_FRAME_CNT_EN
      chk("b_reset_frame", {16'd0, b_frame}, 32'd0);
`endif
      step(2);
      chk("a_reset_held", obs_a, 32'h0000_0000);
      rst  = 1'b0;
      en_a = 1'b1;

      // One full line: hblnk from 800, hsync 840..967, vcount steps at the wrap.
      for (int i = 1; i <= 1056; i++) begin
         step(1);
         chk("a_walk", obs_a, vec_a(i % 1056, (i == 1056) ? 1 : 0));
      end
      chk("a_line_wrap", {21'd0, a_hcount}, 32'd0);

      step(839);
      chk("a_at_839", obs_a, vec_a(839, 1));
      en_a = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk("a_hold", obs_a, vec_a(839, 1));
      end
      en_a = 1'b1;
      step(1);
      chk("a_resume", obs_a, vec_a(840, 1));
      chk("a_resume_hsync", {31'd0, a_hsync}, 32'd1);
      en_a = 1'b0;

      // Small raster: two frames and a bit, sof pulses at each return to (0,0).
      bh = 0; bv = 0; sofs = 0; bf = 16'd0;
      en_b = 1'b1;
      run_b(400);
      chk("b_sof_count", sofs, 32'd2);
      run_b(140);
      chk("b_sof_third", obs_b, vec(0, 0, 1'b1, 8, 2, 3, 6, 1, 2, 0));
      en_b = 1'b0;
      step(1);
      chk("b_hold_sof_clear", obs_b, vec(0, 0, 1'b0, 8, 2, 3, 6, 1, 2, 0));
      step(3);
      chk("b_hold_frozen", obs_b, vec(0, 0, 1'b0, 8, 2, 3, 6, 1, 2, 0));
      en_b = 1'b1;

      // Into hsync and vsync at (11,7), then hit reset between edges.
      run_b(116);
      chk("b_mid_sync", obs_b, {5'd0, 11'd11, 11'd7, 5'b10100});
      #3 rst = 1'b1;
      #1;
      chk("b_async_rst", obs_b, 32'h0000_000A);
      chk("a_async_rst", obs_a, 32'h0000_0000);
      step(2);
      rst = 1'b0;
      bh = 0; bv = 0; bf = 16'd0;
      run_b(1);
      chk("b_restart", obs_b, {5'd0, 11'd1, 11'd0, 5'b01010});
      run_b(20);

`ifdef VGA_TIMING_FRAME_CNT_EN
      force u_b.frame_q = 16'hFFFF;
      #1 release u_b.frame_q;
      bf = 16'hFFFF;
      run_b(180);
      chk("b_frame_wrap", {16'd0, b_frame}, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
